// File: rtl/mipi_csi_rx_frame_controller_pkg.sv
// CSI-2 constants and frame-controller state encoding shared by the
// frame controller and its header detector.
package mipi_csi_rx_frame_controller_pkg;

  localparam int MIPI_GEAR = 8;
  localparam int LANES     = 2;
  localparam int DATA_W    = MIPI_GEAR * LANES;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;
  localparam logic [5:0] DT_RAW14 = 6'h2D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_FRAME   = 2'd2
  } frame_state_e;

  function automatic logic is_line_dt(input logic [5:0] dt);
    return (dt == DT_RAW10) || (dt == DT_RAW12) || (dt == DT_RAW14);
  endfunction

endpackage

// File: rtl/mipi_csi_rx_frame_controller_if.sv
// Aligned 2-lane byte stream: valid plus 16-bit data (lane0 in [7:0]).
interface mipi_csi_rx_frame_controller_if;
  import mipi_csi_rx_frame_controller_pkg::*;

  logic              valid;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);

endinterface

// File: rtl/mipi_csi_rx_header_detector_2lane.sv
// Finds CSI-2 packet headers on the aligned 2-lane stream for one virtual
// channel and classifies them as FS, FE or RAW line packets.
module mipi_csi_rx_header_detector_2lane
  import mipi_csi_rx_frame_controller_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        vc_i,
  output logic              is_fs,
  output logic              is_fe,
  output logic              is_line,
  output logic [15:0]       wc
);

  logic [DATA_W-1:0] d1_q, d1_d;
  logic [DATA_W-1:0] d2_q, d2_d;
  logic              hdr_hit;
  logic [5:0]        di;

  // History clears on any gap so a stale sync word never pairs with new data.
  always_comb begin
    d1_d = '0;
    d2_d = '0;
    if (data_valid_i) begin
      d1_d = data_i;
      d2_d = d1_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  always_comb begin
    di      = d1_q[5:0];
    hdr_hit = data_valid_i && (d2_q == {SYNC_BYTE, SYNC_BYTE}) && (d1_q[7:6] == vc_i);
    is_fs   = hdr_hit && (di == DT_FS);
    is_fe   = hdr_hit && (di == DT_FE);
    is_line = hdr_hit && is_line_dt(di);
    wc      = {data_i[7:0], d1_q[15:8]};
  end

endmodule

// File: rtl/mipi_csi_rx_frame_controller.sv
// Tracks FS/FE framing for one virtual channel, gates decoder valid to
// in-frame traffic, and counts lines/frames with framing-error pulses.
module mipi_csi_rx_frame_controller
  import mipi_csi_rx_frame_controller_pkg::*;
#(
  parameter int TIMEOUT_W = 20
)
(
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  mipi_csi_rx_frame_controller_if.slave         rx_if,
  mipi_csi_rx_frame_controller_if.master        dec_if,
  input  logic                                  enable_i,
  input  logic                                  single_shot_i,
  input  logic [1:0]                            vc_i,
  input  logic [15:0]                           expected_lines_i,
  output logic                                  frame_active_o,
  output logic                                  frame_start_o,
  output logic                                  frame_end_o,
  output logic [15:0]                           line_count_o,
  output logic [15:0]                           frame_count_o,
  output logic                                  line_err_o,
  output logic                                  fs_err_o,
  output logic                                  timeout_err_o
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = '1;

  logic        is_fs, is_fe, is_line;
  logic [15:0] hdr_wc;
  wire         unused_hdr_wc = ^hdr_wc;

  frame_state_e         state_q, state_d;
  logic [15:0]          line_cnt_q, line_cnt_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fs_pulse_q, fs_pulse_d;
  logic                 fe_pulse_q, fe_pulse_d;
  logic                 line_err_q, line_err_d;
  logic                 fs_err_q, fs_err_d;
  logic                 to_err_q, to_err_d;

  mipi_csi_rx_header_detector_2lane u_hdr (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .data_valid_i (rx_if.valid),
    .data_i       (rx_if.data),
    .vc_i         (vc_i),
    .is_fs        (is_fs),
    .is_fe        (is_fe),
    .is_line      (is_line),
    .wc           (hdr_wc)
  );

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    timeout_d   = timeout_q;
    fs_pulse_d  = 1'b0;
    fe_pulse_d  = 1'b0;
    line_err_d  = 1'b0;
    fs_err_d    = 1'b0;
    to_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (is_fs) begin
          state_d    = ST_FRAME;
          fs_pulse_d = 1'b1;
          line_cnt_d = '0;
          timeout_d  = '0;
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_FRAME: begin
        // Dropping enable mid-frame is honoured only once FE closes the frame.
        if (is_fe) begin
          fe_pulse_d  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          line_err_d  = (line_cnt_q != expected_lines_i);
          timeout_d   = '0;
          state_d     = (single_shot_i || !enable_i) ? ST_IDLE : ST_WAIT_FS;
        end else if (is_fs) begin
          fs_err_d   = 1'b1;
          fs_pulse_d = 1'b1;
          line_cnt_d = '0;
          timeout_d  = '0;
        end else if (is_line) begin
          if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
          timeout_d = '0;
        end else if (timeout_q == (TIMEOUT_MAX - TIMEOUT_ONE)) begin
          to_err_d  = 1'b1;
          timeout_d = '0;
          state_d   = ST_WAIT_FS;
        end else begin
          timeout_d = timeout_q + TIMEOUT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FS bytes are blocked because the gate looks at the current state; the
  // FE-completing word is blocked explicitly so the gate closes on that edge.
  always_comb begin
    data_d  = rx_if.data;
    valid_d = rx_if.valid && (state_q == ST_FRAME) && !is_fe;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      timeout_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      fs_pulse_q  <= 1'b0;
      fe_pulse_q  <= 1'b0;
      line_err_q  <= 1'b0;
      fs_err_q    <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      fs_pulse_q  <= fs_pulse_d;
      fe_pulse_q  <= fe_pulse_d;
      line_err_q  <= line_err_d;
      fs_err_q    <= fs_err_d;
      to_err_q    <= to_err_d;
    end
  end

  assign dec_if.data    = data_q;
  assign dec_if.valid   = valid_q;
  assign frame_active_o = (state_q == ST_FRAME);
  assign frame_start_o  = fs_pulse_q;
  assign frame_end_o    = fe_pulse_q;
  assign line_count_o   = line_cnt_q;
  assign frame_count_o  = frame_cnt_q;
  assign line_err_o     = line_err_q;
  assign fs_err_o       = fs_err_q;
  assign timeout_err_o  = to_err_q;

endmodule

// File: tb/tb_mipi_csi_rx_frame_controller.sv
// Scoreboard bench for the CSI-2 frame controller: drives packets on the
// aligned stream and checks gated data, pulses and counters.
module tb_mipi_csi_rx_frame_controller;

  typedef struct {
    logic [15:0] data;
    logic        valid;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic        single_shot_i;
  logic [1:0]  vc_i;
  logic [15:0] expected_lines_i;
  logic        frame_active_o, frame_start_o, frame_end_o;
  logic [15:0] line_count_o, frame_count_o;
  logic        line_err_o, fs_err_o, timeout_err_o;

  mipi_csi_rx_frame_controller_if rx_bus ();
  mipi_csi_rx_frame_controller_if dec_bus ();

  mipi_csi_rx_frame_controller #(.TIMEOUT_W(4)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .rx_if            (rx_bus),
    .dec_if           (dec_bus),
    .enable_i         (enable_i),
    .single_shot_i    (single_shot_i),
    .vc_i             (vc_i),
    .expected_lines_i (expected_lines_i),
    .frame_active_o   (frame_active_o),
    .frame_start_o    (frame_start_o),
    .frame_end_o      (frame_end_o),
    .line_count_o     (line_count_o),
    .frame_count_o    (frame_count_o),
    .line_err_o       (line_err_o),
    .fs_err_o         (fs_err_o),
    .timeout_err_o    (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  int   m_state;
  int   cyc = 0;
  int   cyc_fs = 0;
  int   cyc_to = 0;
  int   n_fs, n_fe, n_line_err, n_fs_err, n_to, n_fe_le, n_fs_fe;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounts();
    n_fs = 0; n_fe = 0; n_line_err = 0; n_fs_err = 0; n_to = 0; n_fe_le = 0; n_fs_fe = 0;
  endtask

  // One stream word per clock; expectation queued at drive, retired after the edge.
  task automatic applyStimulus(input logic [15:0] data, input logic valid, input logic pass);
    exp_t e;
    rx_bus.data  = data;
    rx_bus.valid = valid;
    e.data  = data;
    e.valid = valid & pass;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    cyc++;
    e = exp_q.pop_front();
    checkOutput("data_o", 32'(dec_bus.data), 32'(e.data));
    checkOutput("data_valid_o", 32'(dec_bus.valid), 32'(e.valid));
    if (frame_start_o) begin n_fs++; cyc_fs = cyc; end
    if (frame_end_o) n_fe++;
    if (line_err_o) n_line_err++;
    if (fs_err_o) n_fs_err++;
    if (timeout_err_o) begin n_to++; cyc_to = cyc; end
    if (frame_end_o && line_err_o) n_fe_le++;
    if (fs_err_o && frame_start_o) n_fs_fe++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic sendShort(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
    logic accepted, in_frame, fe;
    accepted = (vc == vc_i);
    in_frame = (m_state == 2);
    fe       = accepted && (dt == 6'h01);
    applyStimulus(16'hB8B8, 1'b1, in_frame);
    applyStimulus({wc[7:0], vc, dt}, 1'b1, in_frame);
    applyStimulus({8'h5A, wc[15:8]}, 1'b1, in_frame && !fe);
    if (accepted) begin
      if (dt == 6'h00 && m_state == 1) m_state = 2;
      else if (dt == 6'h01 && m_state == 2) m_state = (single_shot_i || !enable_i) ? 0 : 1;
    end
  endtask

  task automatic sendLong(input logic [5:0] dt, input logic [1:0] vc, input int n_words, input logic [15:0] base);
    logic        in_frame;
    logic [15:0] wc;
    in_frame = (m_state == 2);
    wc = 16'(n_words * 2);
    applyStimulus(16'hB8B8, 1'b1, in_frame);
    applyStimulus({wc[7:0], vc, dt}, 1'b1, in_frame);
    applyStimulus({8'h33, wc[15:8]}, 1'b1, in_frame);
    for (int i = 0; i < n_words; i++) applyStimulus(base + 16'(i), 1'b1, in_frame);
    idleCycles(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n_i = 1'b0;
    enable_i = 1'b0;
    single_shot_i = 1'b0;
    vc_i = 2'd0;
    expected_lines_i = 16'd0;
    rx_bus.valid = 1'b0;
    rx_bus.data = 16'h0000;
    m_state = 0;
    clearCounts();
    #12;
    checkOutput("reset data_valid_o", 32'(dec_bus.valid), 32'd0);
    checkOutput("reset frame_active_o", 32'(frame_active_o), 32'd0);
    checkOutput("reset line_count_o", 32'(line_count_o), 32'd0);
    checkOutput("reset frame_count_o", 32'(frame_count_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    idleCycles(2);

    $display("[TB] basic frame");
    enable_i = 1'b1;
    expected_lines_i = 16'd2;
    idleCycles(2);
    m_state = 1;
    clearCounts();
    sendShort(6'h00, 2'd0, 16'h0001);
    idleCycles(1);
    checkOutput("t1 frame_start", 32'(n_fs), 32'd1);
    checkOutput("t1 frame_active", 32'(frame_active_o), 32'd1);
    sendLong(6'h2B, 2'd0, 2, 16'h1000);
    sendLong(6'h2B, 2'd0, 2, 16'h2000);
    sendShort(6'h01, 2'd0, 16'h0001);
    idleCycles(1);
    checkOutput("t1 frame_end", 32'(n_fe), 32'd1);
    checkOutput("t1 line_count", 32'(line_count_o), 32'd2);
    checkOutput("t1 frame_count", 32'(frame_count_o), 32'd1);
    checkOutput("t1 line_err", 32'(n_line_err), 32'd0);
    checkOutput("t1 frame_active after FE", 32'(frame_active_o), 32'd0);

    $display("[TB] line mismatch");
    expected_lines_i = 16'd3;
    clearCounts();
    sendShort(6'h00, 2'd0, 16'h0002);
    idleCycles(1);
    sendLong(6'h2C, 2'd0, 2, 16'h3000);
    sendLong(6'h2C, 2'd0, 3, 16'h4000);
    sendShort(6'h01, 2'd0, 16'h0002);
    idleCycles(1);
    checkOutput("t2 frame_start", 32'(n_fs), 32'd1);
    checkOutput("t2 fe with line_err", 32'(n_fe_le), 32'd1);
    checkOutput("t2 line_count", 32'(line_count_o), 32'd2);
    checkOutput("t2 frame_count", 32'(frame_count_o), 32'd2);

    $display("[TB] wrong vc and single shot");
    expected_lines_i = 16'd1;
    clearCounts();
    sendShort(6'h00, 2'd1, 16'h0003);
    idleCycles(1);
    sendLong(6'h2B, 2'd0, 2, 16'h5000);
    checkOutput("t3 wrong vc frame_start", 32'(n_fs), 32'd0);
    checkOutput("t3 wrong vc frame_active", 32'(frame_active_o), 32'd0);
    single_shot_i = 1'b1;
    sendShort(6'h00, 2'd0, 16'h0004);
    idleCycles(1);
    sendLong(6'h2D, 2'd0, 2, 16'h6000);
    sendShort(6'h01, 2'd0, 16'h0004);
    enable_i = 1'b0;
    idleCycles(2);
    checkOutput("t3 frame_end", 32'(n_fe), 32'd1);
    checkOutput("t3 line_count", 32'(line_count_o), 32'd1);
    checkOutput("t3 frame_count", 32'(frame_count_o), 32'd3);
    checkOutput("t3 line_err", 32'(n_line_err), 32'd0);
    sendShort(6'h00, 2'd0, 16'h0005);
    idleCycles(1);
    checkOutput("t3 fs after single shot", 32'(n_fs), 32'd1);
    checkOutput("t3 frame_active idle", 32'(frame_active_o), 32'd0);

    $display("[TB] missing FE");
    single_shot_i = 1'b0;
    enable_i = 1'b1;
    expected_lines_i = 16'd0;
    idleCycles(2);
    m_state = 1;
    clearCounts();
    sendShort(6'h00, 2'd0, 16'h0006);
    idleCycles(1);
    sendLong(6'h2B, 2'd0, 2, 16'h7000);
    sendShort(6'h00, 2'd0, 16'h0007);
    idleCycles(1);
    checkOutput("t4 fs_err with frame_start", 32'(n_fs_fe), 32'd1);
    checkOutput("t4 frame_start count", 32'(n_fs), 32'd2);
    checkOutput("t4 line_count", 32'(line_count_o), 32'd0);
    checkOutput("t4 frame_count", 32'(frame_count_o), 32'd3);
    checkOutput("t4 frame_active", 32'(frame_active_o), 32'd1);
    sendShort(6'h01, 2'd0, 16'h0007);
    idleCycles(1);
    checkOutput("t4 frame_count after FE", 32'(frame_count_o), 32'd4);
    checkOutput("t4 line_err", 32'(n_line_err), 32'd0);

    $display("[TB] timeout");
    clearCounts();
    sendShort(6'h00, 2'd0, 16'h0008);
    for (int i = 0; i < 40 && n_to == 0; i++) idleCycles(1);
    m_state = 1;
    checkOutput("t5 timeout pulses", 32'(n_to), 32'd1);
    checkOutput("t5 timeout latency", 32'(cyc_to - cyc_fs), 32'd15);
    checkOutput("t5 frame_active", 32'(frame_active_o), 32'd0);
    checkOutput("t5 frame_count", 32'(frame_count_o), 32'd4);
    checkOutput("t5 frame_end", 32'(n_fe), 32'd0);

    $display("[TB] reset mid-frame");
    clearCounts();
    sendShort(6'h00, 2'd0, 16'h0009);
    idleCycles(1);
    applyStimulus(16'hB8B8, 1'b1, 1'b1);
    applyStimulus({8'h04, 2'd0, 6'h2B}, 1'b1, 1'b1);
    applyStimulus(16'h3300, 1'b1, 1'b1);
    applyStimulus(16'h8001, 1'b1, 1'b1);
    rx_bus.data = 16'h8002;
    reset_n_i = 1'b0;
    #2;
    checkOutput("t6 reset data_o", 32'(dec_bus.data), 32'd0);
    checkOutput("t6 reset data_valid_o", 32'(dec_bus.valid), 32'd0);
    checkOutput("t6 reset frame_active", 32'(frame_active_o), 32'd0);
    checkOutput("t6 reset line_count", 32'(line_count_o), 32'd0);
    checkOutput("t6 reset frame_count", 32'(frame_count_o), 32'd0);
    enable_i = 1'b0;
    rx_bus.valid = 1'b0;
    rx_bus.data = 16'h0000;
    m_state = 0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    idleCycles(3);
    clearCounts();
    sendShort(6'h00, 2'd0, 16'h000A);
    idleCycles(1);
    checkOutput("t6 fs while idle", 32'(n_fs), 32'd0);
    enable_i = 1'b1;
    idleCycles(2);
    m_state = 1;
    sendShort(6'h00, 2'd0, 16'h000B);
    idleCycles(1);
    checkOutput("t6 fs after enable", 32'(n_fs), 32'd1);
    checkOutput("t6 frame_active", 32'(frame_active_o), 32'd1);
    sendShort(6'h01, 2'd0, 16'h000B);
    idleCycles(1);
    checkOutput("t6 frame_count", 32'(frame_count_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mipi_csi_rx_frame_controller.md
Name: mipi_csi_rx_frame_controller

Overview:
- Sits between the 2-lane lane aligner and the RAW packet decoder.
- Parses CSI-2 packet headers on the aligned 16-bit stream and tracks Frame Start / Frame End short packets for one virtual channel.
- Gates the decoder's data-valid so only in-frame traffic reaches it; supports single-shot and continuous capture.
- Counts lines and frames, and flags framing errors: line-count mismatch, missing FE, header timeout.

Parameters:
- MIPI_GEAR, 8, bits per lane per clock.
- LANES, 2, lane count. Header parsing is defined for 2 lanes only.
- TIMEOUT_W, 20, width of the in-frame inactivity counter. Timeout fires at 2^TIMEOUT_W-1 cycles.

Ports:
- clk_i  in  1  mipi byte clock
- reset_n_i  in  1  asynchronous active-low reset
- data_valid_i  in  1  aligned data valid from lane aligner
- data_i  in  16  aligned bytes; lane0 = [7:0], lane1 = [15:8]
- enable_i  in  1  capture enable (level)
- single_shot_i  in  1  1 = return to IDLE after one frame
- vc_i  in  2  virtual channel to accept
- expected_lines_i  in  16  long packets expected per frame
- data_o  out  16  data_i delayed one cycle, to decoder
- data_valid_o  out  1  gated valid, to decoder
- frame_active_o  out  1  state == FRAME
- frame_start_o  out  1  one-cycle pulse on accepted FS
- frame_end_o  out  1  one-cycle pulse on accepted FE
- line_count_o  out  16  long packets seen in current/last frame
- frame_count_o  out  16  completed frames, wraps
- line_err_o  out  1  pulse: line count != expected at FE
- fs_err_o  out  1  pulse: FS while in FRAME
- timeout_err_o  out  1  pulse: in-frame timeout

Behaviour:
- Reset (asynchronous, reset_n_i low): state IDLE. All outputs, counters and pipeline registers 0.
- Header pipeline: d1 <= data_i and d2 <= d1 when data_valid_i. Both clear to 0 when data_valid_i is low.
- Header detection is combinational on the cycle where data_valid_i=1, d2=={B8,B8} and d1[7:6]==vc_i.
  - DI = d1[5:0].
  - WC = {data_i[7:0], d1[15:8]} (unused except for lines).
  - Word order: {B8,B8}, {WC_lsb,DI}, {ECC,WC_msb}. At most one header per cycle.
- Packet classes:
  - FS: DI 0x00.
  - FE: DI 0x01.
  - LINE: DI 0x2B, 0x2C or 0x2D.
  - All other DI values are ignored.
- FSM states: IDLE, WAIT_FS, FRAME.
- IDLE:
  - enable_i=1 -> WAIT_FS.
- WAIT_FS:
  - FS -> FRAME; frame_start_o pulse; line counter <= 0; timeout counter <= 0.
  - enable_i=0 -> IDLE.
  - FE and LINE are ignored.
- FRAME:
  - LINE -> line counter +1, saturating at 0xFFFF; timeout counter <= 0.
  - FE:
    - frame_end_o pulse; frame_count_o +1 (wraps at 0xFFFF->0).
    - line_err_o pulse if line count != expected_lines_i.
    - Next state IDLE if single_shot_i or !enable_i, else WAIT_FS.
  - FS:
    - fs_err_o and frame_start_o pulse in the same cycle.
    - Line counter <= 0; stay in FRAME; frame_count_o unchanged.
  - Otherwise the timeout counter increments every cycle, whether or not data is valid.
    - When it reaches all-ones: timeout_err_o pulse, go to WAIT_FS, frame_count_o unchanged.
  - enable_i falling inside FRAME does not abort. The frame completes and exits at FE.
- All pulses are registered and asserted the cycle after the detecting edge.
- line_count_o holds its value after FE until the next accepted FS.
- Datapath: data_o <= data_i every cycle. data_valid_o <= data_valid_i & (state==FRAME), registered, so latency is 1.
  - The gate opens the cycle after FS is detected, so FS bytes are never passed.
  - FE's first two words pass through. The decoder discards them because the DI is not RAW.
  - The gate closes on the clock edge where FE is detected.
- reset_n_i asserted mid-frame: immediate IDLE, data_valid_o=0, counters cleared.

Decomposition:
- Shared package holds the CSI constants: SYNC_BYTE 0xB8, DT_FS 0x00, DT_FE 0x01, DT_RAW10/12/14 0x2B/0x2C/0x2D, and the state encoding.
- One natural sub-module: mipi_csi_rx_header_detector_2lane.
  - Contains d1/d2, VC match and class decode.
  - Outputs is_fs, is_fe, is_line and wc.
- The FSM and counters remain in the top.

Test Plan:
- Basic frame: enable=1, single_shot=0, vc=0, expected=2. Drive FS, then two RAW10 packets (WC=4), then FE.
  - Response: frame_start_o pulse; data_valid_o high only between FS detection and FE detection.
  - At FE: line_count_o=2, frame_count_o=1, line_err_o=0; state returns to WAIT_FS.
- Line mismatch: expected=3, frame with 2 RAW12 lines.
  - Response: frame_end_o and line_err_o pulse in the same cycle; line_count_o=2.
- Wrong VC and single-shot:
  - FS with DI 0x40 while vc_i=0 -> ignored, data_valid_o stays 0.
  - Then single_shot=1 and a valid frame -> FSM ends in IDLE; a subsequent FS is ignored.
- Missing FE: FS, one line, FS again.
  - Response: fs_err_o and frame_start_o pulse together; line_count_o=0; frame_count_o unchanged.
- Timeout: TIMEOUT_W=4, FS then 15 idle cycles.
  - Response: timeout_err_o pulse; state WAIT_FS; data_valid_o low.
- Reset mid-frame: assert reset_n_i during a line payload.
  - Response: all outputs 0 asynchronously; after release the FSM waits in IDLE until enable_i is high.
